stage_m: RTL and testbench
==========================

Name: stage_m

Overview:
- Memory stage of the 5-stage combi core; consumes execute-stage outputs (ALUResultE, WriteDataE, RdE, RegWriteE, MemWriteE, ResultSrcE, PCPlus4E) and feeds the writeback stage.
- Holds the E/M pipeline register, drives a req/gnt/rvalid data-memory port, and raises StallM to the hazard unit while an access is incomplete.
- Exports ALUResultM and RdM/RegWriteM for the execute forwarding muxes.

Parameters:
- WIDTH, 32, datapath and address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ALUResultE  in  WIDTH  address / ALU result from execute
- WriteDataE  in  WIDTH  store data, post-forwarding
- RdE  in  5  destination register
- RegWriteE, MemWriteE  in  1 each  execute control
- ResultSrcE  in  2  00 = ALU, 01 = load, 10 = PC+4
- PCPlus4E  in  WIDTH  link value
- ALUResultM, WriteDataM, PCPlus4M  out  WIDTH  registered copies
- RdM  out  5; RegWriteM  out  1; ResultSrcM  out  2  registered copies
- ReadDataM  out  WIDTH  load data, valid in the completing cycle
- StallM  out  1  hold E/M and all earlier stages; bubble into W
- dmem_req  out  1; dmem_we  out  1; dmem_addr  out  WIDTH; dmem_wdata  out  WIDTH
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1; dmem_rdata  in  WIDTH  load response

Behaviour:
- E/M register
  - Loads all E inputs on a rising clk when StallM = 0; holds when StallM = 1.
  - rst clears all fields to 0: every registered output is 0 after reset.
- Operation decode
  - loadM = (ResultSrcM == 01).
  - storeM = MemWriteM.
  - memop = loadM | storeM. Both set together is illegal; treat as load.
- FSM states: IDLE, RESP. Reset state is IDLE.
- IDLE
  - dmem_req = memop.
  - dmem_we = storeM.
  - dmem_addr = ALUResultM; dmem_wdata = WriteDataM.
  - Store with gnt: complete this cycle; stay in IDLE.
  - Load with gnt: go to RESP.
  - No gnt: stay in IDLE with req held and address/data stable.
- RESP
  - dmem_req = 0.
  - When rvalid: the load completes; go to IDLE.
  - rvalid is never earlier than the cycle after gnt; rvalid seen in IDLE is ignored.
- complete = (IDLE & storeM & gnt) | (RESP & rvalid).
- StallM = memop & ~complete. This is a combinational gnt/rvalid-to-StallM path.
  - A store with immediate gnt costs 0 stall cycles.
  - A load costs at least 1 stall cycle.
- ReadDataM = dmem_rdata when (RESP & rvalid), else 0. W latches it on the completing edge.
- Non-memory instructions: no req, StallM = 0.
- Back-to-back memops: the next instruction enters M on the completing edge and may assert req the following cycle.
- rst mid-access: FSM returns to IDLE and req drops the same edge. Memory shares rst, so no stale response arrives.

Optional Feature:
- Macro: STAGE_M_WBUF_EN. Adds a one-entry posted store buffer (addr, data, valid).
- With the macro, stores:
  - A store in M with the buffer empty is captured into the buffer and completes that cycle (StallM = 0) without waiting for gnt.
  - A store in M with the buffer full stalls until the buffer drains.
- With the macro, drain and loads:
  - The buffer drives req/we = 1 whenever it is valid. It has priority over M.
  - The buffer clears on gnt.
  - A load waits (StallM = 1) until the buffer is empty, which keeps program order.
- rst clears the buffer.
- Without the macro: no buffer, and behaviour is exactly as above.

Test Plan:
- Store, zero-wait: MemWriteE = 1, addr 0x100, data 0xDEADBEEF, gnt tied 1 -> req/we = 1 with 0x100/0xDEADBEEF for one cycle, StallM never 1.
- Load, one-cycle latency: ResultSrcE = 01, addr 0x200, gnt immediate, rvalid next cycle with 0x12345678 -> StallM = 1 for one cycle, ReadDataM = 0x12345678 in the completing cycle, RdM held.
- Grant backpressure: load with gnt low 3 cycles, then rvalid 2 cycles after gnt -> req held 4 cycles with stable addr, StallM = 1 for 5 cycles, E/M outputs unchanged throughout.
- Back-to-back: store 0x10 then load 0x10, gnt = 1, rvalid = 1 cycle after gnt -> two distinct requests in order; forwarding sees ALUResultM = 0x10 for each.
- Reset in RESP: assert rst while waiting for rvalid -> next cycle state IDLE, req = 0, StallM = 0, all outputs 0.
- STAGE_M_WBUF_EN: store with gnt low, then load -> store completes with no stall; load stalls until the buffer gets gnt; the load req is issued only after the buffer drains.

Source files
------------

// File: rtl/stage_m.sv
// Memory stage: E/M pipeline register, req/gnt/rvalid data-memory port and StallM generation.
// Optional one-entry posted store buffer enabled with `define STAGE_M_WBUF_EN.
module stage_m #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [4:0]       RdE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic [WIDTH-1:0] PCPlus4E,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] PCPlus4M,
    output logic [4:0]       RdM,
    output logic             RegWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             StallM,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [WIDTH-1:0] dmem_rdata
);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_q, wdata_q, pcplus4_q;
    logic [4:0]       rd_q;
    logic             regwrite_q, memwrite_q;
    logic [1:0]       resultsrc_q;

    logic load_m, store_m, memop, complete;

`ifdef STAGE_M_WBUF_EN
    logic             wb_valid_q, wb_valid_d;
    logic [WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
`endif

    // Load wins when both load and store are flagged.
    assign load_m  = (resultsrc_q == 2'b01);
    assign store_m = memwrite_q & ~load_m;
    assign memop   = load_m | memwrite_q;

    always_comb begin
        state_d    = state_q;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = alu_q;
        dmem_wdata = wdata_q;
        complete   = 1'b0;
`ifdef STAGE_M_WBUF_EN
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef STAGE_M_WBUF_EN
                // A pending buffered store owns the port; loads wait behind it.
                if (wb_valid_q) begin
                    dmem_req   = 1'b1;
                    dmem_we    = 1'b1;
                    dmem_addr  = wb_addr_q;
                    dmem_wdata = wb_data_q;
                    if (dmem_gnt) begin
                        wb_valid_d = 1'b0;
                    end
                end else if (store_m) begin
                    wb_valid_d = 1'b1;
                    wb_addr_d  = alu_q;
                    wb_data_d  = wdata_q;
                    complete   = 1'b1;
                end else if (load_m) begin
                    dmem_req = 1'b1;
                    if (dmem_gnt) begin
                        state_d = StResp;
                    end
                end
`else
                dmem_req = memop;
                dmem_we  = store_m;
                if (store_m && dmem_gnt) begin
                    complete = 1'b1;
                end
                if (load_m && dmem_gnt) begin
                    state_d = StResp;
                end
`endif
            end
            StResp: begin
                if (dmem_rvalid) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end
            end
        endcase
    end

    assign StallM    = memop & ~complete;
    assign ReadDataM = (state_q == StResp && dmem_rvalid) ? dmem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            alu_q       <= '0;
            wdata_q     <= '0;
            pcplus4_q   <= '0;
            rd_q        <= '0;
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            resultsrc_q <= '0;
        end else begin
            state_q <= state_d;
            if (!StallM) begin
                alu_q       <= ALUResultE;
                wdata_q     <= WriteDataE;
                pcplus4_q   <= PCPlus4E;
                rd_q        <= RdE;
                regwrite_q  <= RegWriteE;
                memwrite_q  <= MemWriteE;
                resultsrc_q <= ResultSrcE;
            end
        end
    end

`ifdef STAGE_M_WBUF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end
`endif

    assign ALUResultM = alu_q;
    assign WriteDataM = wdata_q;
    assign PCPlus4M   = pcplus4_q;
    assign RdM        = rd_q;
    assign RegWriteM  = regwrite_q;
    assign ResultSrcM = resultsrc_q;

endmodule

// File: tb/tb_stage_m.sv
// Directed self-checking bench for stage_m; inputs change 1ns after posedge, checks 1ns later.
module tb_stage_m;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE;
    logic [1:0]  ResultSrcE;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, ReadDataM;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        StallM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    stage_m #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .RdE        (RdE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .ResultSrcE (ResultSrcE),
        .PCPlus4E   (PCPlus4E),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_e(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [31:0] pc);
        ALUResultE = alu;
        WriteDataE = wd;
        RdE        = rd;
        RegWriteE  = rw;
        MemWriteE  = mw;
        ResultSrcE = rs;
        PCPlus4E   = pc;
    endtask

    task automatic nop();
        set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0);
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, ".alu"}, ALUResultM, 32'h0);
        chk({tag, ".wd"}, WriteDataM, 32'h0);
        chk({tag, ".pc"}, PCPlus4M, 32'h0);
        chk({tag, ".ctl"}, {24'h0, RdM, RegWriteM, ResultSrcM}, 32'h0);
        chk({tag, ".req"}, {31'h0, dmem_req}, 32'h0);
        chk({tag, ".stall"}, {31'h0, StallM}, 32'h0);
        chk({tag, ".rdata"}, ReadDataM, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        nop();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        set_e(32'hFFFF_FFFF, 32'h1234, 5'd31, 1'b1, 1'b1, 2'b10, 32'h88);
        tick();
        tick();
        settle();
        chk_regs_zero("reset");
        rst = 1'b0;

        // Non-memory op with PC+4 result: registered copy, no request, no stall.
        set_e(32'hA5A5_0000, 32'h0, 5'd1, 1'b1, 1'b0, 2'b10, 32'h0000_0104);
        tick();
        nop();
        settle();
        chk("nonmem.pc", PCPlus4M, 32'h0000_0104);
        chk("nonmem.ctl", {24'h0, RdM, RegWriteM, ResultSrcM}, {24'h0, 5'd1, 1'b1, 2'b10});
        chk("nonmem.req", {31'h0, dmem_req}, 32'h0);
        chk("nonmem.stall", {31'h0, StallM}, 32'h0);
        tick();

`ifndef STAGE_M_WBUF_EN
        // Store with immediate grant.
        dmem_gnt = 1'b1;
        set_e(32'h100, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 2'b00, 32'h0);
        tick();
        nop();
        settle();
        chk("st.reqwe", {30'h0, dmem_req, dmem_we}, 32'h3);
        chk("st.addr", dmem_addr, 32'h100);
        chk("st.wdata", dmem_wdata, 32'hDEAD_BEEF);
        chk("st.stall", {31'h0, StallM}, 32'h0);
        tick();
        settle();
        chk("st.after.req", {31'h0, dmem_req}, 32'h0);
        chk("st.after.stall", {31'h0, StallM}, 32'h0);
`endif

        // Load, immediate grant, rvalid one cycle later.
        dmem_gnt = 1'b1;
        set_e(32'h200, 32'h0, 5'd5, 1'b1, 1'b0, 2'b01, 32'h44);
        tick();
        nop();
        settle();
        chk("ld.req", {30'h0, dmem_req, dmem_we}, 32'h2);
        chk("ld.addr", dmem_addr, 32'h200);
        chk("ld.stall", {31'h0, StallM}, 32'h1);
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        settle();
        chk("ld.resp.req", {31'h0, dmem_req}, 32'h0);
        chk("ld.resp.stall", {31'h0, StallM}, 32'h0);
        chk("ld.resp.rdata", ReadDataM, 32'h1234_5678);
        chk("ld.resp.rd", {27'h0, RdM}, 32'd5);
        chk("ld.resp.alu", ALUResultM, 32'h200);
        tick();
        dmem_rvalid = 1'b0;
        settle();
        chk("ld.done.stall", {31'h0, StallM}, 32'h0);
        chk("ld.done.rdata", ReadDataM, 32'h0);
        chk("ld.done.rd", {27'h0, RdM}, 32'd0);

        // Load with three cycles of grant backpressure, rvalid two cycles after grant.
        dmem_gnt = 1'b0;
        set_e(32'h300, 32'h0, 5'd7, 1'b1, 1'b0, 2'b01, 32'h48);
        tick();
        set_e(32'hAAAA, 32'hBBBB, 5'd2, 1'b1, 1'b0, 2'b00, 32'hCC);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp.req", {31'h0, dmem_req}, 32'h1);
            chk("bp.addr", dmem_addr, 32'h300);
            chk("bp.stall", {31'h0, StallM}, 32'h1);
            chk("bp.rd", {27'h0, RdM}, 32'd7);
            tick();
        end
        dmem_gnt = 1'b1;
        settle();
        chk("bp.gnt.req", {31'h0, dmem_req}, 32'h1);
        chk("bp.gnt.stall", {31'h0, StallM}, 32'h1);
        tick();
        dmem_gnt = 1'b0;
        settle();
        chk("bp.wait.req", {31'h0, dmem_req}, 32'h0);
        chk("bp.wait.stall", {31'h0, StallM}, 32'h1);
        chk("bp.wait.alu", ALUResultM, 32'h300);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        settle();
        chk("bp.resp.stall", {31'h0, StallM}, 32'h0);
        chk("bp.resp.rdata", ReadDataM, 32'hCAFE_F00D);
        tick();
        dmem_rvalid = 1'b0;
        nop();
        settle();
        chk("bp.next.alu", ALUResultM, 32'hAAAA);
        chk("bp.next.pc", PCPlus4M, 32'hCC);
        tick();

`ifndef STAGE_M_WBUF_EN
        // Store then load to the same address, back to back.
        dmem_gnt = 1'b1;
        set_e(32'h10, 32'h55, 5'd0, 1'b0, 1'b1, 2'b00, 32'h0);
        tick();
        set_e(32'h10, 32'h0, 5'd3, 1'b1, 1'b0, 2'b01, 32'h0);
        settle();
        chk("b2b.st.reqwe", {30'h0, dmem_req, dmem_we}, 32'h3);
        chk("b2b.st.alu", ALUResultM, 32'h10);
        chk("b2b.st.stall", {31'h0, StallM}, 32'h0);
        tick();
        nop();
        settle();
        chk("b2b.ld.reqwe", {30'h0, dmem_req, dmem_we}, 32'h2);
        chk("b2b.ld.alu", ALUResultM, 32'h10);
        chk("b2b.ld.stall", {31'h0, StallM}, 32'h1);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h55;
        settle();
        chk("b2b.resp.req", {31'h0, dmem_req}, 32'h0);
        chk("b2b.resp.rdata", ReadDataM, 32'h55);
        tick();
        dmem_rvalid = 1'b0;
`else
        // Posted store with grant low, followed by a load that must wait for the drain.
        dmem_gnt = 1'b0;
        set_e(32'h600, 32'h77, 5'd0, 1'b0, 1'b1, 2'b00, 32'h0);
        tick();
        set_e(32'h604, 32'h0, 5'd4, 1'b1, 1'b0, 2'b01, 32'h0);
        settle();
        chk("wb.cap.stall", {31'h0, StallM}, 32'h0);
        chk("wb.cap.req", {31'h0, dmem_req}, 32'h0);
        tick();
        nop();
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("wb.drain.reqwe", {30'h0, dmem_req, dmem_we}, 32'h3);
            chk("wb.drain.addr", dmem_addr, 32'h600);
            chk("wb.drain.wdata", dmem_wdata, 32'h77);
            chk("wb.drain.stall", {31'h0, StallM}, 32'h1);
            tick();
        end
        dmem_gnt = 1'b1;
        settle();
        chk("wb.gnt.addr", dmem_addr, 32'h600);
        chk("wb.gnt.stall", {31'h0, StallM}, 32'h1);
        tick();
        settle();
        chk("wb.ld.reqwe", {30'h0, dmem_req, dmem_we}, 32'h2);
        chk("wb.ld.addr", dmem_addr, 32'h604);
        chk("wb.ld.stall", {31'h0, StallM}, 32'h1);
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h9999;
        settle();
        chk("wb.resp.stall", {31'h0, StallM}, 32'h0);
        chk("wb.resp.rdata", ReadDataM, 32'h9999);
        tick();
        dmem_rvalid = 1'b0;
`endif

        // Load and store flagged together behaves as a load.
        dmem_gnt = 1'b0;
        set_e(32'h500, 32'h66, 5'd6, 1'b1, 1'b1, 2'b01, 32'h0);
        tick();
        nop();
        settle();
        chk("ill.reqwe", {30'h0, dmem_req, dmem_we}, 32'h2);
        chk("ill.stall", {31'h0, StallM}, 32'h1);
        dmem_gnt = 1'b1;
        tick();
        // Now waiting in RESP: reset mid-access.
        dmem_gnt = 1'b0;
        settle();
        chk("rst.pre.stall", {31'h0, StallM}, 32'h1);
        chk("rst.pre.req", {31'h0, dmem_req}, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk_regs_zero("rst.resp");
        // Stray rvalid after reset must be ignored in IDLE.
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hBAD0_BAD0;
        settle();
        chk("rst.stray.rdata", ReadDataM, 32'h0);
        chk("rst.stray.stall", {31'h0, StallM}, 32'h0);
        dmem_rvalid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
